// File: rtl/mp_add_pkg.sv
// Shared types and default sizing for the sequential multi-precision adder.
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEF     = 8;
  localparam int LIMBS_DEF = 4;

endpackage

// File: rtl/limb_adder.sv
// Combinational N-bit limb adder with carry-in and carry-out.
module limb_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
  assign s    = full[N-1:0];
  assign co   = full[N];

endmodule

// File: rtl/mp_add_seq.sv
// Sequential multi-precision adder: one limb per cycle through a shared limb_adder.
// Define MP_ADD_SEQ_SUB_EN to add the 'sub' input (a-b via ~b and carry-in 1).
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LIMBS = LIMBS_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [N*LIMBS-1:0] a,
  input  logic [N*LIMBS-1:0] b,
`ifdef MP_ADD_SEQ_SUB_EN
  input  logic               sub,
`endif
  output logic [N*LIMBS-1:0] sum,
  output logic               cf,
  output logic               ovf,
  output logic               busy,
  output logic               done
);

  localparam int W  = N * LIMBS;
  localparam int CW = $clog2(LIMBS);
  localparam logic [CW-1:0] LAST = CW'(LIMBS - 1);

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [CW-1:0] idx;
  logic          carry;
  logic [N-1:0]  a_limb;
  logic [N-1:0]  b_limb;
  logic [N-1:0]  s_limb;
  logic          co;
  logic          sub_req;

`ifdef MP_ADD_SEQ_SUB_EN
  assign sub_req = sub;
`else
  assign sub_req = 1'b0;
`endif

  assign a_limb = a_q[idx*N +: N];
  assign b_limb = b_q[idx*N +: N];

  limb_adder #(.N(N)) u_limb_adder (
    .a  (a_limb),
    .b  (b_limb),
    .ci (carry),
    .s  (s_limb),
    .co (co)
  );

  // b is stored pre-inverted for subtraction, so the msb used for ovf is already the effective one.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cf    <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= sub_req ? ~b : b;
            carry <= sub_req;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum[idx*N +: N] <= s_limb;
          carry           <= co;
          if (idx == LAST) begin
            cf    <= co;
            ovf   <= a_q[W-1] ^ b_q[W-1] ^ s_limb[N-1] ^ co;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq (N=8, LIMBS=4): directed corner cases plus random operands vs. an arithmetic model.
module tb_mp_add_seq;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub_in = 1'b0;
  logic [31:0] sum;
  logic        cf, ovf, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  mp_add_seq #(.N(8), .LIMBS(4)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef MP_ADD_SEQ_SUB_EN
    .sub   (sub_in),
`endif
    .sum   (sum),
    .cf    (cf),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: plain 32-bit arithmetic; overflow from operand/result signs.
  task automatic model(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                       output logic [31:0] es, output logic ec, output logic eo);
    logic [32:0] wide;
    if (ts) begin
      es = ta - tb_;
      ec = (ta >= tb_);
      eo = (ta[31] != tb_[31]) && (es[31] != ta[31]);
    end else begin
      wide = {1'b0, ta} + {1'b0, tb_};
      es = wide[31:0];
      ec = wide[32];
      eo = (ta[31] == tb_[31]) && (es[31] != ta[31]);
    end
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts, input string tag);
    int cycles;
    bit got;
    logic [31:0] es;
    logic ec, eo;
    model(ta, tb_, ts, es, ec, eo);
    @(negedge clk);
    a = ta; b = tb_; sub_in = ts; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = $urandom; b = $urandom; sub_in = 1'b0;
    cycles = 0; got = 0;
    while (!got && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (done) got = 1;
      else chk({tag, " busy_run"}, 64'(busy), 64'd1);
    end
    chk({tag, " latency"}, 64'(cycles), 64'd5);
    chk({tag, " busy_done"}, 64'(busy), 64'd1);
    chk({tag, " sum"}, 64'(sum), 64'(es));
    chk({tag, " cf"}, 64'(cf), 64'(ec));
    chk({tag, " ovf"}, 64'(ovf), 64'(eo));
    @(negedge clk);
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
    chk({tag, " idle"}, 64'(busy), 64'd0);
    chk({tag, " sum_hold"}, 64'(sum), 64'(es));
  endtask

  initial begin
    int n_done;
    logic [31:0] es, ra, rb;
    logic ec, eo, rs;

    #12;
    chk("rst sum", 64'(sum), 64'd0);
    chk("rst cf", 64'(cf), 64'd0);
    chk("rst ovf", 64'(ovf), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    @(negedge clk);
    clr = 1'b0;

    run_op(32'h000000FF, 32'h00000001, 1'b0, "carry_chain");
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, "wrap");
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, "pos_ovf");
    run_op(32'h80000000, 32'h80000000, 1'b0, "neg_ovf");

    // Second start two cycles into an operation must be ignored.
    model(32'h12345678, 32'h11111111, 1'b0, es, ec, eo);
    @(negedge clk);
    a = 32'h12345678; b = 32'h11111111; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 32'hFFFF0000; b = 32'h0000FFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("ignore done_count", 64'(n_done), 64'd1);
    chk("ignore sum", 64'(sum), 64'(es));
    chk("ignore cf", 64'(cf), 64'(ec));

    // Asynchronous clear mid-operation, after limb 1 has been processed.
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    chk("clr busy", 64'(busy), 64'd0);
    chk("clr done", 64'(done), 64'd0);
    chk("clr sum", 64'(sum), 64'd0);
    chk("clr cf", 64'(cf), 64'd0);
    @(negedge clk);
    clr = 1'b0;
    run_op(32'hDEADBEEF, 32'h01234567, 1'b0, "after_clr");

`ifdef MP_ADD_SEQ_SUB_EN
    run_op(32'h00000000, 32'h00000001, 1'b1, "sub_borrow");
    run_op(32'h80000000, 32'h00000001, 1'b1, "sub_ovf");
    run_op(32'h00000005, 32'h00000005, 1'b1, "sub_zero");
`endif

    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      rb = $urandom;
`ifdef MP_ADD_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rs, $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mp_add_seq.md
MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 SHALL have parameter N, default 8, limb width in bits.
REQ-002 SHALL have parameter LIMBS, default 4, number of limbs per operand (>=2).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port clr  input  1  asynchronous active-high reset.
REQ-005 SHALL have port start  input  1  request to begin an operation.
REQ-006 SHALL have port a  input  N*LIMBS  first operand, sampled on accepted start.
REQ-007 SHALL have port b  input  N*LIMBS  second operand, sampled on accepted start.
REQ-008 SHALL have port sum  output  N*LIMBS  registered result.
REQ-009 SHALL have port cf  output  1  carry out of most-significant limb.
REQ-010 SHALL have port ovf  output  1  two's-complement overflow of full-width result.
REQ-011 SHALL have port busy  output  1  high while an operation is in progress.
REQ-012 SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 at a clock edge SHALL latch a and b, clear the limb counter, set the internal carry to 0 and enter RUN.
REQ-015 In RUN, each cycle SHALL add limb[i] of the latched a and b plus the carry through one shared N-bit adder, write sum limb i, register the carry-out and increment i.
REQ-016 After limb LIMBS-1 is processed, RUN SHALL enter DONE, with cf = final carry-out and ovf = a_msb ^ b_msb ^ sum_msb ^ cf.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-018 Latency from the start edge to done high SHALL be LIMBS+1 cycles; one result per LIMBS+2 cycles at most.
REQ-019 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-020 start while busy=1 SHALL be ignored, with no effect on operands, counter or outputs.
REQ-021 sum, cf and ovf SHALL hold their values from the end of DONE until the next accepted start; during RUN they are undefined to the user.
REQ-022 Limb arithmetic SHALL be unsigned N+1 bits; the counter SHALL be clog2(LIMBS) bits and SHALL not wrap within an operation.

Reset
REQ-023 clr=1 SHALL asynchronously force IDLE and clear sum, cf, ovf, busy, done, the counter and the carry, including mid-operation.
REQ-024 The first start after clr deasserts SHALL be accepted normally.

Configuration
REQ-025 Macro MP_ADD_SEQ_SUB_EN defined: SHALL add input sub (1 bit, sampled with start).
REQ-026 With sub=1, the block SHALL compute a-b using ~b and an initial carry of 1; cf=1 means no borrow; ovf uses the inverted b msb.
REQ-027 Macro undefined: SHALL have no sub port and SHALL perform addition only, with identical timing.

Structure
REQ-028 A shared package mp_add_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default N and LIMBS constants.
REQ-029 The limb adder SHALL be a sub-module limb_adder (N-bit a, b, carry-in; N-bit sum, carry-out), instantiated once.

Verification (N=8, LIMBS=4)
REQ-030 a=0x000000FF, b=0x00000001, start -> done after 5 cycles; sum=0x00000100, cf=0, ovf=0 (inter-limb carry).
REQ-031 a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, cf=1, ovf=0; a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cf=0, ovf=1.
REQ-032 A second start pulse, with different operands, 2 cycles after an accepted start -> ignored; result matches the first operands; exactly one done pulse.
REQ-033 clr pulsed during RUN (after limb 1) -> busy=0, done=0, sum=0 immediately; a following start completes correctly.
REQ-034 With MP_ADD_SEQ_SUB_EN: a=0, b=1, sub=1 -> sum=0xFFFFFFFF, cf=0, ovf=0; a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1.
